// File: rtl/crc_stream_pkg.sv
// Shared constants and FSM state type for the streaming CRC engine.
package crc_stream_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    CRC_STATE_IDLE  = 2'd0,
    CRC_STATE_ACCUM = 2'd1,
    CRC_STATE_SHIFT = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_stream_step.sv
// Combinational CRC update: folds one IN_WIDTH-bit beat into the running register.
module crc_step #(
  parameter int unsigned        CRC_LEN  = 32,
  parameter logic [CRC_LEN-1:0] POLY     = 32'h04C11DB7,
  parameter int unsigned        IN_WIDTH = 2,
  parameter int unsigned        REFLECT  = 1
) (
  input  logic [CRC_LEN-1:0]  crc_in,
  input  logic [IN_WIDTH-1:0] din,
  output logic [CRC_LEN-1:0]  crc_out
);

  function automatic logic [CRC_LEN-1:0] reflect(input logic [CRC_LEN-1:0] v);
    logic [CRC_LEN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CRC_LEN; i++) r[i] = v[CRC_LEN-1-i];
    return r;
  endfunction

  // Reflected mode keeps the register bit-reversed so the LSB is the feedback tap.
  localparam logic [CRC_LEN-1:0] POLY_R = reflect(POLY);

  logic [CRC_LEN-1:0] r;
  logic               fb;

  always_comb begin
    r  = crc_in;
    fb = 1'b0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (REFLECT != 0) begin
        fb = r[0] ^ din[i];
        r  = (r >> 1) ^ (fb ? POLY_R : '0);
      end else begin
        fb = r[CRC_LEN-1] ^ din[IN_WIDTH-1-i];
        r  = (r << 1) ^ (fb ? POLY : '0);
      end
    end
    crc_out = r;
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: accumulate, shift FCS out under flow control, residue check.
// Optional residue comparator enabled by defining CRC_STREAM_CHECK_EN.
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int unsigned        CRC_LEN  = 32,
  parameter logic [CRC_LEN-1:0] POLY     = CRC32_POLY,
  parameter logic [CRC_LEN-1:0] INIT     = CRC32_INIT,
  parameter logic [CRC_LEN-1:0] XOR_OUT  = CRC32_XOR_OUT,
  parameter int unsigned        IN_WIDTH = 2,
  parameter int unsigned        REFLECT  = 1,
  parameter logic [CRC_LEN-1:0] RESIDUE  = CRC32_RESIDUE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                inclk,
  input  logic [IN_WIDTH-1:0] in,
  input  logic                in_done,
  input  logic                shift,
  input  logic                readclk,
  output logic                outclk,
  output logic [IN_WIDTH-1:0] out,
  output logic [CRC_LEN-1:0]  crc,
  output logic                busy,
  output logic                done,
  output logic                ok,
  output logic                err
);

  localparam int unsigned NCHUNK = CRC_LEN / IN_WIDTH;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

  crc_state_e         state_q, state_d;
  logic [CRC_LEN-1:0] crc_reg_q, crc_reg_d;
  logic [CRC_LEN-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               outclk_q, outclk_d;
  logic               done_q, done_d;
  logic               check_d;
  logic [CRC_LEN-1:0] step_crc, acc_crc;

  crc_step #(
    .CRC_LEN (CRC_LEN),
    .POLY    (POLY),
    .IN_WIDTH(IN_WIDTH),
    .REFLECT (REFLECT)
  ) u_step (
    .crc_in (crc_reg_q),
    .din    (in),
    .crc_out(step_crc)
  );

  always_comb begin
    // A beat arriving with in_done/shift is folded in before the check or FCS load.
    acc_crc   = inclk ? step_crc : crc_reg_q;
    state_d   = state_q;
    crc_reg_d = crc_reg_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    outclk_d  = 1'b0;
    done_d    = 1'b0;
    check_d   = 1'b0;
    if (start) begin
      state_d   = CRC_STATE_ACCUM;
      crc_reg_d = INIT;
    end else begin
      case (state_q)
        CRC_STATE_ACCUM: begin
          crc_reg_d = acc_crc;
          if (in_done) begin
            state_d = CRC_STATE_IDLE;
            check_d = 1'b1;
          end else if (shift) begin
            state_d  = CRC_STATE_SHIFT;
            sr_d     = acc_crc ^ XOR_OUT;
            cnt_d    = CNT_W'(NCHUNK);
            outclk_d = 1'b1;
          end
        end
        CRC_STATE_SHIFT: begin
          if (readclk) begin
            sr_d  = (REFLECT != 0) ? (sr_q >> IN_WIDTH) : (sr_q << IN_WIDTH);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = CRC_STATE_IDLE;
              done_d  = 1'b1;
            end else begin
              outclk_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CRC_STATE_IDLE;
      crc_reg_q <= INIT;
      sr_q      <= '0;
      cnt_q     <= '0;
      outclk_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_reg_q <= crc_reg_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      outclk_q  <= outclk_d;
      done_q    <= done_d;
    end
  end

`ifdef CRC_STREAM_CHECK_EN
  logic ok_q, ok_d, err_q, err_d;

  always_comb begin
    ok_d  = check_d && (acc_crc == RESIDUE);
    err_d = check_d && (acc_crc != RESIDUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ok_q  <= ok_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    ok  = ok_q;
    err = err_q;
  end
`else
  logic unused_check;

  always_comb begin
    unused_check = check_d ^ (^RESIDUE);
    ok           = 1'b0;
    err          = 1'b0;
  end
`endif

  always_comb begin
    outclk = outclk_q;
    done   = done_q;
    busy   = (state_q != CRC_STATE_IDLE);
    crc    = crc_reg_q ^ XOR_OUT;
    out    = '0;
    if (state_q == CRC_STATE_SHIFT)
      out = (REFLECT != 0) ? sr_q[IN_WIDTH-1:0] : sr_q[CRC_LEN-1 -: IN_WIDTH];
  end

endmodule

// File: tb/tb_crc_stream.sv
// Directed self-checking bench for crc_stream: dibit and byte-wide instances.
module tb_crc_stream;

`ifdef CRC_STREAM_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  localparam logic [31:0] FCS = 32'hCBF43926;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic a_start, a_inclk, a_in_done, a_shift, a_readclk;
  logic [1:0] a_in, a_out;
  logic a_outclk, a_busy, a_done, a_ok, a_err;
  logic [31:0] a_crc;

  logic b_start, b_inclk, b_in_done, b_shift, b_readclk;
  logic [7:0] b_in, b_out;
  logic b_outclk, b_busy, b_done, b_ok, b_err;
  logic [31:0] b_crc;

  crc_stream #(.IN_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(a_start), .inclk(a_inclk), .in(a_in),
    .in_done(a_in_done), .shift(a_shift), .readclk(a_readclk), .outclk(a_outclk),
    .out(a_out), .crc(a_crc), .busy(a_busy), .done(a_done), .ok(a_ok), .err(a_err)
  );

  crc_stream #(.IN_WIDTH(8), .REFLECT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .inclk(b_inclk), .in(b_in),
    .in_done(b_in_done), .shift(b_shift), .readclk(b_readclk), .outclk(b_outclk),
    .out(b_out), .crc(b_crc), .busy(b_busy), .done(b_done), .ok(b_ok), .err(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame2(input logic [103:0] d, input int len, input bit chk);
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = d[(len-1-i)*8 +: 8];
      for (int k = 0; k < 4; k++) begin
        a_inclk = 1'b1;
        a_in    = b[2*k +: 2];
        if (chk && i == len-1 && k == 3) a_in_done = 1'b1;
        tick();
      end
    end
    if (chk && len == 0) begin a_in_done = 1'b1; tick(); end
    a_inclk = 1'b0; a_in_done = 1'b0; a_in = '0;
  endtask

  task automatic frame8(input logic [103:0] d, input int len, input bit chk);
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      b_inclk = 1'b1;
      b_in    = d[(len-1-i)*8 +: 8];
      if (chk && i == len-1) b_in_done = 1'b1;
      tick();
    end
    if (chk && len == 0) begin b_in_done = 1'b1; tick(); end
    b_inclk = 1'b0; b_in_done = 1'b0; b_in = '0;
  endtask

  typedef struct {
    string        name;
    logic [103:0] data;
    int           len;
    bit           chk;
    bit           chk_crc;
    logic [31:0]  crc;
    bit           good;
  } frame_t;

  frame_t tbl [6];

  int n, dn, idx;
  logic [1:0] first_o, last_o;
  bit eo, ed, rd;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"check9",  {32'h0, "123456789"},           9,  1'b0, 1'b1, 32'hCBF43926, 1'b0};
    tbl[1] = '{"good9",   {"123456789", 32'h2639F4CB},    13, 1'b1, 1'b1, 32'h2144DF1C, 1'b1};
    tbl[2] = '{"bad9",    {"023456789", 32'h2639F4CB},    13, 1'b1, 1'b0, 32'h0,        1'b0};
    tbl[3] = '{"a",       {96'h0, "a"},                   1,  1'b0, 1'b1, 32'hE8B7BE43, 1'b0};
    tbl[4] = '{"empty",   104'h0,                         0,  1'b1, 1'b1, 32'h0,        1'b0};
    tbl[5] = '{"good_a",  {64'h0, "a", 32'h43BEB7E8},     5,  1'b1, 1'b1, 32'h2144DF1C, 1'b1};

    rst_n = 1'b0;
    {a_start, a_inclk, a_in_done, a_shift, a_readclk} = '0; a_in = '0;
    {b_start, b_inclk, b_in_done, b_shift, b_readclk} = '0; b_in = '0;
    tick(); tick();

    check("rst_a_crc", a_crc, 32'h0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_a_outclk", a_outclk, 1'b0);
    check("rst_a_out", a_out, 2'b00);
    check("rst_a_flags", {a_done, a_ok, a_err}, 3'b000);
    check("rst_b_crc", b_crc, 32'h0);
    check("rst_b_busy", b_busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Controls other than start are ignored while idle.
    a_inclk = 1'b1; a_in = 2'b11; a_in_done = 1'b1; a_shift = 1'b1; a_readclk = 1'b1;
    tick();
    {a_inclk, a_in_done, a_shift, a_readclk} = '0; a_in = '0;
    check("idle_crc", a_crc, 32'h0);
    check("idle_busy", a_busy, 1'b0);
    check("idle_outclk", a_outclk, 1'b0);
    check("idle_okerr", {a_ok, a_err}, 2'b00);

    for (int t = 0; t < 6; t++) begin
      frame2(tbl[t].data, tbl[t].len, tbl[t].chk);
      if (tbl[t].chk_crc) check({"crc2_", tbl[t].name}, a_crc, tbl[t].crc);
      check({"ok2_", tbl[t].name}, a_ok, CHECK && tbl[t].good);
      check({"err2_", tbl[t].name}, a_err, CHECK && tbl[t].chk && !tbl[t].good);
      tick();
      check({"busy2_", tbl[t].name}, a_busy, !tbl[t].chk);
      check({"pulse2_", tbl[t].name}, {a_ok, a_err}, 2'b00);

      frame8(tbl[t].data, tbl[t].len, tbl[t].chk);
      if (tbl[t].chk_crc) check({"crc8_", tbl[t].name}, b_crc, tbl[t].crc);
      check({"ok8_", tbl[t].name}, b_ok, CHECK && tbl[t].good);
      check({"err8_", tbl[t].name}, b_err, CHECK && tbl[t].chk && !tbl[t].good);
      tick();
      check({"busy8_", tbl[t].name}, b_busy, !tbl[t].chk);
      check({"pulse8_", tbl[t].name}, {b_ok, b_err}, 2'b00);
    end

    // Dibit shift-out with readclk held high.
    frame2({32'h0, "123456789"}, 9, 1'b0);
    a_shift = 1'b1; a_readclk = 1'b1;
    tick();
    a_shift = 1'b0;
    n = 0; dn = 0; first_o = 2'bxx; last_o = 2'bxx;
    for (int c = 0; c < 40; c++) begin
      if (a_outclk) begin
        check("shift2_out", a_out, FCS[2*(n%16) +: 2]);
        if (n == 0) first_o = a_out;
        last_o = a_out;
        n++;
      end
      if (a_done) begin
        dn++;
        check("shift2_busy_at_done", a_busy, 1'b0);
        break;
      end
      tick();
    end
    check("shift2_chunks", n, 16);
    check("shift2_done", dn, 1);
    check("shift2_first", first_o, 2'b10);
    check("shift2_last", last_o, 2'b11);
    a_readclk = 1'b0;
    tick();
    check("shift2_done_pulse", a_done, 1'b0);
    check("shift2_idle", {a_busy, a_outclk}, 2'b00);

    // Byte shift-out with readclk once every five cycles.
    frame8({32'h0, "123456789"}, 9, 1'b0);
    b_shift = 1'b1; tick(); b_shift = 1'b0;
    idx = 0; eo = 1'b1; ed = 1'b0;
    for (int c = 0; c < 60; c++) begin
      check("gap_outclk", b_outclk, eo);
      check("gap_done", b_done, ed);
      if (ed) break;
      check("gap_out", b_out, FCS[8*(idx%4) +: 8]);
      rd = (c % 5 == 4);
      b_readclk = rd; tick(); b_readclk = 1'b0;
      ed = rd && idx == 3;
      eo = rd && idx < 3;
      if (rd) idx++;
    end
    check("gap_chunks", idx, 4);
    check("gap_busy", b_busy, 1'b0);

    // Synchronous reset in the middle of a shift-out.
    frame2({32'h0, "123456789"}, 9, 1'b0);
    a_shift = 1'b1; tick(); a_shift = 1'b0;
    a_readclk = 1'b1; tick(); tick(); a_readclk = 1'b0;
    rst_n = 1'b0; tick();
    check("rst_mid_outclk", a_outclk, 1'b0);
    check("rst_mid_out", a_out, 2'b00);
    check("rst_mid_busy", a_busy, 1'b0);
    check("rst_mid_flags", {a_done, a_ok, a_err}, 3'b000);
    check("rst_mid_crc", a_crc, 32'h0);
    rst_n = 1'b1; tick();
    check("rst_mid_nodone", a_done, 1'b0);

    // Restart in the middle of accumulation.
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_inclk = 1'b1; a_in = 2'b01; tick(); tick(); tick(); a_inclk = 1'b0;
    check("restart_dirty", (a_crc != 32'h0), 1'b1);
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("restart_crc", a_crc, 32'h0);
    check("restart_busy", a_busy, 1'b1);
    frame2({32'h0, "123456789"}, 9, 1'b0);
    check("restart_frame", a_crc, 32'hCBF43926);

    // Restart aborts a shift-out without done.
    frame8({32'h0, "123456789"}, 9, 1'b0);
    b_shift = 1'b1; tick(); b_shift = 1'b0;
    b_readclk = 1'b1; tick(); b_readclk = 1'b0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    check("abort_outclk", b_outclk, 1'b0);
    check("abort_out", b_out, 8'h00);
    check("abort_busy", b_busy, 1'b1);
    check("abort_crc", b_crc, 32'h0);
    b_readclk = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("abort_quiet", {b_outclk, b_done}, 2'b00);
    end
    b_readclk = 1'b0;
    b_in_done = 1'b1; tick(); b_in_done = 1'b0;
    check("abort_err", {b_ok, b_err}, {1'b0, CHECK});

    // in_done and shift together: check wins, shift dropped.
    frame8({"123456789", 32'h2639F4CB}, 13, 1'b0);
    b_in_done = 1'b1; b_shift = 1'b1; tick(); {b_in_done, b_shift} = '0;
    check("both_busy", b_busy, 1'b0);
    check("both_ok", {b_ok, b_err}, {CHECK, 1'b0});
    b_readclk = 1'b1; tick(); tick(); b_readclk = 1'b0;
    check("both_nooutclk", {b_outclk, b_done, b_busy}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
